ddr_rd_checker: RTL and testbench

DDR_RD_CHECKER -- requirements
Module: ddr_rd_checker

---
 rtl/ddr_rd_checker_pkg.sv | 26 ++
 rtl/ddr_rd_checker_pat_cmp.sv | 25 ++
 rtl/ddr_rd_checker.sv | 169 ++++++++++++++++
 tb/tb_ddr_rd_checker.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_checker_pkg.sv
// DDR read checker shared definitions.
// State encoding, address field widths and address packing.
package ddr_rd_checker_pkg;

  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int BANK_W = 2;
  localparam int ADDR_W = ROW_W + COL_W + BANK_W;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    XFER,
    NEXT
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [ROW_W-1:0]  row,
    input logic [COL_W-1:0]  col,
    input logic [BANK_W-1:0] bank
  );
    return {row, col, bank};
  endfunction

endpackage

// File: rtl/ddr_rd_checker_pat_cmp.sv
// Expected-pattern generator and beat comparator.
// Fixed seed, or seed plus beat index when PAT_INC is set.
module ddr_pat_cmp
  import ddr_rd_checker_pkg::*;
#(
  parameter logic [31:0] PRELOAD = 32'hA5A5_5A5A,
  parameter int          PAT_INC = 0
) (
  input  logic [COL_W-1:0] beat,
  input  logic [31:0]      data,
  output logic             mismatch
);

  logic [31:0] exp_data;

  // build the expected word and compare
  always_comb begin
    exp_data = PRELOAD;
    if (PAT_INC != 0) begin
      exp_data = PRELOAD + 32'(beat);
    end
    mismatch = (data != exp_data);
  end

endmodule

// File: rtl/ddr_rd_checker.sv
// DDR read-sweep checker: requests one line per row,
// checks every beat, tracks errors and a watchdog.
module ddr_rd_checker
  import ddr_rd_checker_pkg::*;
#(
  parameter logic [9:0]  XFR_LEN  = 10'h200,
  parameter logic [12:0] ROW_LAST = 13'h1FFF,
  parameter logic [31:0] PRELOAD  = 32'hA5A5_5A5A,
  parameter int          PAT_INC  = 0,
  parameter logic [9:0]  WDOG_MAX = 10'h3FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_mem_req,
  output logic [ADDR_W-1:0] rd_mem_addr,
  output logic [9:0]        rd_xfr_len,
  input  logic              rd_mem_grant,
  input  logic [31:0]       rd_data,
  input  logic              rd_data_valid,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ROW_W-1:0]  row_cnt
);

  state_t state_q;
  state_t state_d;

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] beat_q;
  logic [9:0]       wdog_q;

  logic in_data;
  logic beat_ok;
  logic overrun;
  logic last_beat;
  logic wdog_exp;
  logic sweep_end;
  logic mismatch;

  ddr_pat_cmp #(
    .PRELOAD (PRELOAD),
    .PAT_INC (PAT_INC)
  ) u_cmp (
    .beat     (beat_q),
    .data     (rd_data),
    .mismatch (mismatch)
  );

  // decode qualifiers from the current state
  always_comb begin
    in_data   = (state_q == WAIT_DATA) || (state_q == XFER);
    beat_ok   = in_data && rd_data_valid;
    overrun   = rd_data_valid && !in_data;
    last_beat = (beat_q == XFR_LEN - 10'd1);
    wdog_exp  = (wdog_q == WDOG_MAX - 10'd1);
    sweep_end = (row_q == ROW_LAST) || abort;
    rd_mem_req = (state_q == REQ);
    busy       = (state_q != IDLE);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = REQ;
      end
      REQ: begin
        if (rd_mem_grant) state_d = WAIT_DATA;
      end
      WAIT_DATA, XFER: begin
        if (rd_data_valid) begin
          state_d = last_beat ? NEXT : XFER;
        end else if (wdog_exp) begin
          state_d = IDLE;
        end
      end
      NEXT: begin
        state_d = sweep_end ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // counters, request fields and error bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q          <= '0;
      beat_q         <= '0;
      wdog_q         <= '0;
      rd_mem_addr    <= '0;
      rd_xfr_len     <= '0;
      done           <= 1'b0;
      err_flag       <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      row_cnt        <= '0;
    end else begin
      done <= (state_q != IDLE) && (state_d == IDLE);

      if (state_q == IDLE && start) begin
        row_q          <= '0;
        rd_mem_addr    <= pack_addr('0, '0, '0);
        rd_xfr_len     <= XFR_LEN;
        err_flag       <= 1'b0;
        timeout        <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        row_cnt        <= '0;
      end

      if (state_q == REQ && rd_mem_grant) begin
        beat_q <= '0;
        wdog_q <= '0;
      end

      if (beat_ok) begin
        beat_q <= beat_q + 10'd1;
        wdog_q <= '0;
      end else if (in_data) begin
        wdog_q <= wdog_q + 10'd1;
      end

      if (beat_ok && mismatch) begin
        err_flag <= 1'b1;
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (err_cnt == 16'd0) begin
          first_err_addr <= pack_addr(row_q, beat_q, 2'b00);
        end
      end

      if (overrun) begin
        err_flag <= 1'b1;
      end

      if (in_data && !rd_data_valid && wdog_exp) begin
        timeout  <= 1'b1;
        err_flag <= 1'b1;
      end

      if (state_q == NEXT) begin
        row_cnt <= row_cnt + 13'd1;
        if (!sweep_end) begin
          row_q       <= row_q + 13'd1;
          rd_mem_addr <= pack_addr(row_q + 13'd1, '0, '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Scoreboard bench for ddr_rd_checker.
// Random memory responder, sweep-level reference model.
module tb_ddr_rd_checker;

  localparam logic [12:0] ROW_LAST = 13'd1;
  localparam logic [31:0] PRE      = 32'hA5A5_5A5A;
  localparam int          XL       = 512;
  localparam int          WD       = 1023;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        rd_mem_req;
  logic [24:0] rd_mem_addr;
  logic [9:0]  rd_xfr_len;
  logic        rd_mem_grant;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        busy;
  logic        done;
  logic        err_flag;
  logic        timeout;
  logic [15:0] err_cnt;
  logic [24:0] first_err_addr;
  logic [12:0] row_cnt;

  ddr_rd_checker #(
    .ROW_LAST (ROW_LAST),
    .PRELOAD  (PRE),
    .PAT_INC  (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .rd_mem_req     (rd_mem_req),
    .rd_mem_addr    (rd_mem_addr),
    .rd_xfr_len     (rd_xfr_len),
    .rd_mem_grant   (rd_mem_grant),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid),
    .busy           (busy),
    .done           (done),
    .err_flag       (err_flag),
    .timeout        (timeout),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .row_cnt        (row_cnt)
  );

  typedef struct {
    logic [12:0] row_cnt;
    logic [15:0] err_cnt;
    logic [24:0] fea;
    logic        err_flag;
    logic        timeout;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int done_cyc = 0;
  int beats_sent = 0;
  int stop_at = -1;
  bit mute = 0;
  bit extra = 0;
  bit bad[int];

  logic [24:0] exp_addr_q[$];
  res_t        exp_res_q[$];
  logic [24:0] mon_addr;
  res_t        mon_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // memory manager model: grant 3 cycles after req, then a line
  initial begin
    int row;
    rd_mem_grant  = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    forever begin
      tick();
      if (rd_mem_req && !rst) begin
        tick();
        tick();
        rd_mem_grant = 1'b1;
        gnt_cyc = cyc;
        row = int'(rd_mem_addr[24:12]);
        tick();
        rd_mem_grant = 1'b0;
        if (!mute) begin
          for (int b = 0; b < XL; b++) begin
            if (b == stop_at) break;
            rd_data_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            rd_data_valid = 1'b1;
            rd_data = bad.exists(row * 1024 + b) ? 32'h0 : PRE + 32'(b);
            tick();
            beats_sent++;
          end
          if (extra && stop_at < 0) begin
            rd_data = 32'h0;
            rd_data_valid = 1'b1;
            tick();
          end
          rd_data_valid = 1'b0;
        end
      end
    end
  end

  // monitor: checks requests and end-of-sweep results
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_mem_req && rd_mem_grant) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: got %h expected none", rd_mem_addr);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          chk("req_addr", 32'(rd_mem_addr), 32'(mon_addr));
          chk("xfr_len", 32'(rd_xfr_len), XL);
        end
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          mon_res = exp_res_q.pop_front();
          chk("row_cnt", 32'(row_cnt), 32'(mon_res.row_cnt));
          chk("err_cnt", 32'(err_cnt), 32'(mon_res.err_cnt));
          chk("first_err_addr", 32'(first_err_addr), 32'(mon_res.fea));
          chk("err_flag", 32'(err_flag), 32'(mon_res.err_flag));
          chk("timeout", 32'(timeout), 32'(mon_res.timeout));
          chk("busy_at_done", 32'(busy), 0);
        end
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_req"}, 32'(rd_mem_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err_flag"}, 32'(err_flag), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_fea"}, 32'(first_err_addr), 0);
    chk({tag, "_row_cnt"}, 32'(row_cnt), 0);
    chk({tag, "_addr"}, 32'(rd_mem_addr), 0);
    chk({tag, "_xfr_len"}, 32'(rd_xfr_len), 0);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (beats_sent < n && t < 20000) begin
      tick();
      t++;
    end
    if (beats_sent < n) fail("wait_beats");
  endtask

  task automatic wait_done();
    int t = 0;
    while (t < 10000) begin
      tick();
      t++;
      if (done) break;
    end
    if (!done) fail("wait_done");
    done_cyc = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // one sweep: model predicts requests and final status
  task automatic sweep(input bit do_abort, input int abort_at,
                       input bit busy_start);
    int   rows;
    int   first;
    res_t r;
    rows = do_abort ? 1 : int'(ROW_LAST) + 1;
    for (int i = 0; i < (mute ? 1 : rows); i++) begin
      exp_addr_q.push_back(25'(i * 4096));
    end
    r.row_cnt = mute ? 13'd0 : 13'(rows);
    r.err_cnt = '0;
    r.fea = '0;
    first = -1;
    if (!mute) begin
      foreach (bad[k]) begin
        if (k / 1024 < rows) begin
          r.err_cnt++;
          if (first < 0) first = k;
        end
      end
    end
    if (first >= 0) r.fea = 25'((first / 1024) * 4096 + (first % 1024) * 4);
    r.err_flag = (r.err_cnt != 0) || extra || mute;
    r.timeout = mute;
    exp_res_q.push_back(r);
    beats_sent = 0;
    pulse_start();
    if (busy_start) begin
      wait_beats(50);
      pulse_start();
    end
    if (do_abort) begin
      wait_beats(abort_at);
      abort = 1'b1;
    end
    wait_done();
    abort = 1'b0;
    if (!mute) chk("beats_total", beats_sent, rows * XL);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b0;
    tick();

    // clean two-row sweep
    sweep(0, 0, 0);

    // beat 5 of row 0 corrupted
    bad[5] = 1;
    sweep(0, 0, 0);
    bad.delete();

    // random corruption, overruns and ignored starts
    for (int s = 0; s < 4; s++) begin
      bad.delete();
      repeat ($urandom_range(0, 3)) begin
        bad[$urandom_range(0, int'(ROW_LAST)) * 1024 +
            $urandom_range(0, XL - 1)] = 1;
      end
      extra = 1'($urandom_range(0, 1));
      sweep(0, 0, 1'($urandom_range(0, 1)));
    end
    bad.delete();

    // directed overrun after beat 511
    extra = 1;
    sweep(0, 0, 0);
    extra = 0;

    // abort mid-line in row 0
    bad[300] = 1;
    sweep(1, 100, 0);
    bad.delete();

    // no data after grant
    mute = 1;
    sweep(0, 0, 0);
    mute = 0;
    chk("timeout_latency", done_cyc - gnt_cyc, WD + 1);

    // reset in the middle of a line, then restart
    exp_addr_q.push_back(25'h0);
    beats_sent = 0;
    stop_at = 200;
    pulse_start();
    wait_beats(200);
    rst = 1'b1;
    tick();
    check_cleared("midrst");
    rst = 1'b0;
    stop_at = -1;
    exp_addr_q.delete();
    exp_res_q.delete();
    repeat (4) tick();
    sweep(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
